// File: rtl/dmem_mmio.sv
// Data-side memory responder for the single-cycle core: word RAM plus an MMIO window
// holding a byte TX FIFO, a status register and a free-running cycle counter.
module dmem_mmio #(
    parameter int          RAM_WORDS  = 64,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] MMIO_BASE  = 32'h0000_1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        TxValid,
    output logic [7:0]  TxData,
    input  logic        TxReady
);

    localparam int          AW      = $clog2(RAM_WORDS);
    localparam int          PW      = $clog2(FIFO_DEPTH);
    localparam int          CW      = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [29:0] BASE_W  = MMIO_BASE[31:2];

    logic [31:0]   ram_r [RAM_WORDS];
    logic [7:0]    fifo_r [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr_r;
    logic [PW-1:0] wr_ptr_r;
    logic [CW-1:0] count_r;
    logic          ovf_r;
    logic [31:0]   cycle_r;
    logic          tx_valid_r;
    logic [7:0]    tx_data_r;

    logic          ram_hit_s, tx_hit_s, status_hit_s, cycle_hit_s;
    logic [AW-1:0] ram_idx_s;
    logic          full_s, empty_s, push_s, pop_s, enq_s, ovf_set_s;
    logic [CW-1:0] count_nxt_s;
    logic [PW-1:0] rd_nxt_s, wr_nxt_s;
    logic [7:0]    head_nxt_s;
    logic [31:0]   status_s, rdata_s;
    logic          unused_s;

    assign unused_s  = ^DataAdr[1:0];
    assign ram_idx_s = DataAdr[AW+1:2];

    // Address decode; RAM takes priority should the windows ever overlap
    always_comb begin
        ram_hit_s    = (DataAdr[31:AW+2] == '0);
        tx_hit_s     = 1'b0;
        status_hit_s = 1'b0;
        cycle_hit_s  = 1'b0;
        if (!ram_hit_s) begin
            tx_hit_s     = (DataAdr[31:2] == BASE_W);
            status_hit_s = (DataAdr[31:2] == BASE_W + 30'd1);
            cycle_hit_s  = (DataAdr[31:2] == BASE_W + 30'd2);
        end else begin
            tx_hit_s     = 1'b0;
        end
    end

    // FIFO push/pop arbitration and next-state of pointers, count and head byte
    always_comb begin
        full_s    = (count_r == DEPTH_C);
        empty_s   = (count_r == '0);
        push_s    = MemWrite && tx_hit_s;
        pop_s     = tx_valid_r && TxReady;
        enq_s     = push_s && (!full_s || pop_s);
        ovf_set_s = push_s && full_s && !pop_s;
        rd_nxt_s  = pop_s ? rd_ptr_r + PW'(1) : rd_ptr_r;
        wr_nxt_s  = enq_s ? wr_ptr_r + PW'(1) : wr_ptr_r;
        case ({enq_s, pop_s})
            2'b10:   count_nxt_s = count_r + CW'(1);
            2'b01:   count_nxt_s = count_r - CW'(1);
            default: count_nxt_s = count_r;
        endcase
        // A byte written into the slot that becomes the head must bypass the array
        if (count_nxt_s == '0) begin
            head_nxt_s = 8'h00;
        end else if (enq_s && (wr_ptr_r == rd_nxt_s)) begin
            head_nxt_s = WriteData[7:0];
        end else begin
            head_nxt_s = fifo_r[rd_nxt_s];
        end
    end

    // Load data mux; the TXDATA port and unmapped addresses read as zero
    always_comb begin
        status_s         = 32'h0000_0000;
        status_s[9]      = ovf_r;
        status_s[8]      = full_s;
        status_s[7]      = empty_s;
        status_s[CW-1:0] = count_r;
        if (ram_hit_s) begin
            rdata_s = ram_r[ram_idx_s];
        end else if (status_hit_s) begin
            rdata_s = status_s;
        end else if (cycle_hit_s) begin
            rdata_s = cycle_r;
        end else begin
            rdata_s = 32'h0000_0000;
        end
    end

    assign ReadData = rdata_s;
    assign TxValid  = tx_valid_r;
    assign TxData   = tx_data_r;

    // RAM and FIFO storage arrays: contents are never reset
    always_ff @(posedge clk) begin
        if (!reset && MemWrite && ram_hit_s) begin
            ram_r[ram_idx_s] <= WriteData;
        end
        if (!reset && enq_s) begin
            fifo_r[wr_ptr_r] <= WriteData[7:0];
        end
    end

    // FIFO control, sticky overflow flag and cycle counter
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_r   <= '0;
            wr_ptr_r   <= '0;
            count_r    <= '0;
            ovf_r      <= 1'b0;
            cycle_r    <= 32'h0000_0000;
            tx_valid_r <= 1'b0;
            tx_data_r  <= 8'h00;
        end else begin
            rd_ptr_r   <= rd_nxt_s;
            wr_ptr_r   <= wr_nxt_s;
            count_r    <= count_nxt_s;
            tx_valid_r <= (count_nxt_s != '0);
            tx_data_r  <= head_nxt_s;
            if (ovf_set_s) begin
                ovf_r <= 1'b1;
            end else if (MemWrite && status_hit_s) begin
                ovf_r <= 1'b0;
            end else begin
                ovf_r <= ovf_r;
            end
            if (MemWrite && cycle_hit_s) begin
                cycle_r <= 32'h0000_0000;
            end else begin
                cycle_r <= cycle_r + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_dmem_mmio.sv
// Bench for dmem_mmio: directed scenarios followed by random traffic, all checked
// against a queue/array reference model of the memory map.
module tb_dmem_mmio;

    localparam int          DEPTH = 8;
    localparam logic [31:0] MB    = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        reset, MemWrite, TxReady, TxValid;
    logic [31:0] DataAdr, WriteData, ReadData;
    logic [7:0]  TxData;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] m_ram [64];
    bit          m_known [64];
    logic [7:0]  m_q [$];
    logic        m_ovf = 1'b0;
    logic [31:0] m_cyc = 32'h0;

    logic [31:0] obs_rd;
    logic        obs_v;
    logic [7:0]  obs_d;

    dmem_mmio dut (
        .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr),
        .WriteData(WriteData), .ReadData(ReadData), .TxValid(TxValid),
        .TxData(TxData), .TxReady(TxReady)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [31:0] a, output bit known);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        known = 1'b1;
        if (w < 32'd256) begin
            known = m_known[w[7:2]];
            return m_ram[w[7:2]];
        end
        if (w == MB + 32'd4)
            return {22'b0, m_ovf, m_q.size() == DEPTH, m_q.size() == 0, 3'b0, 4'(m_q.size())};
        if (w == MB + 32'd8)
            return m_cyc;
        return 32'h0;
    endfunction

    // One clock: drive at negedge, check all outputs against the model, update model at posedge
    task automatic step(input logic rst, input logic we, input logic [31:0] adr,
                        input logic [31:0] wd, input logic rdy);
        logic [31:0] e, w;
        bit kn, pop, push, full;
        @(negedge clk);
        reset = rst; MemWrite = we; DataAdr = adr; WriteData = wd; TxReady = rdy;
        #1;
        obs_rd = ReadData; obs_v = TxValid; obs_d = TxData;
        e = m_read(adr, kn);
        if (kn) chk("rdata", obs_rd, e);
        chk("txvalid", {31'b0, obs_v}, {31'b0, m_q.size() != 0});
        if (m_q.size() != 0) chk("txdata", {24'b0, obs_d}, {24'b0, m_q[0]});
        @(posedge clk);
        w = {adr[31:2], 2'b00};
        if (rst) begin
            m_q.delete();
            m_ovf = 1'b0;
            m_cyc = 32'h0;
        end else begin
            pop  = (m_q.size() != 0) && rdy;
            full = (m_q.size() == DEPTH);
            push = we && (w == MB);
            if (pop) m_q.delete(0);
            if (push) begin
                if (!full || pop) m_q.push_back(wd[7:0]);
                else m_ovf = 1'b1;
            end
            if (we && w == MB + 32'd4) m_ovf = 1'b0;
            m_cyc = (we && w == MB + 32'd8) ? 32'h0 : m_cyc + 32'd1;
            if (we && w < 32'd256) begin
                m_ram[w[7:2]]   = wd;
                m_known[w[7:2]] = 1'b1;
            end
        end
    endtask

    initial begin
        logic [31:0] adr;
        logic [7:0]  exp_b;
        int          r;
        reset = 1'b1; MemWrite = 1'b0; DataAdr = 32'h0; WriteData = 32'h0; TxReady = 1'b0;
        step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        step(1'b0, 1'b0, MB + 32'd8, 32'h0, 1'b0);
        chk("cycle_after_reset", obs_rd, 32'h0);
        chk("txvalid_after_reset", {31'b0, obs_v}, 32'h0);
        step(1'b0, 1'b0, MB + 32'd4, 32'h0, 1'b0);
        chk("status_after_reset", obs_rd, 32'h0000_0080);

        // RAM store/load, unaligned address, read-during-write
        step(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0);
        step(1'b0, 1'b0, 32'h10, 32'h0, 1'b0);
        chk("ram_load", obs_rd, 32'hDEAD_BEEF);
        step(1'b0, 1'b0, 32'h13, 32'h0, 1'b0);
        chk("ram_load_unaligned", obs_rd, 32'hDEAD_BEEF);
        step(1'b0, 1'b1, 32'h10, 32'h1234_5678, 1'b0);
        chk("ram_rdw_old", obs_rd, 32'hDEAD_BEEF);
        step(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0);

        // Three pushes then drain in order
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, MB, 32'h41 + i, 1'b0);
        step(1'b0, 1'b0, MB + 32'd4, 32'h0, 1'b0);
        chk("status_count3", obs_rd, 32'h0000_0003);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 32'h2000, 32'h0, 1'b1);
            chk("drain_byte", {24'b0, obs_d}, 32'h41 + i);
        end
        step(1'b0, 1'b0, MB + 32'd4, 32'h0, 1'b1);
        chk("drain_empty_valid", {31'b0, obs_v}, 32'h0);
        chk("drain_empty_status", obs_rd, 32'h0000_0080);

        // Overflow: DEPTH+1 pushes, sticky flag, clear by STATUS write
        for (int i = 0; i <= DEPTH; i++) step(1'b0, 1'b1, MB, 32'h60 + i, 1'b0);
        step(1'b0, 1'b0, MB + 32'd4, 32'h0, 1'b0);
        chk("status_ovf_full", obs_rd, 32'h0000_0308);
        step(1'b0, 1'b1, MB + 32'd4, 32'h0, 1'b0);
        step(1'b0, 1'b0, MB + 32'd4, 32'h0, 1'b0);
        chk("status_ovf_cleared", obs_rd, 32'h0000_0108);
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 1'b0, 32'h2000, 32'h0, 1'b1);
            chk("ovf_drain_byte", {24'b0, obs_d}, 32'h60 + i);
        end
        step(1'b0, 1'b0, 32'h2000, 32'h0, 1'b0);
        chk("ovf_drain_done", {31'b0, obs_v}, 32'h0);

        // Push while full with simultaneous pop
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, MB, 32'h70 + i, 1'b0);
        step(1'b0, 1'b1, MB, 32'h55, 1'b1);
        step(1'b0, 1'b0, MB + 32'd4, 32'h0, 1'b0);
        chk("status_full_pushpop", obs_rd, 32'h0000_0108);
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 1'b0, 32'h2000, 32'h0, 1'b1);
            exp_b = (i < DEPTH - 1) ? 8'h71 + 8'(i) : 8'h55;
            chk("pushpop_drain_byte", {24'b0, obs_d}, {24'b0, exp_b});
        end

        // Cycle counter clear and wrap
        step(1'b0, 1'b1, MB + 32'd8, 32'hFFFF_0000, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h2000, 32'h0, 1'b0);
        step(1'b0, 1'b0, MB + 32'd8, 32'h0, 1'b0);
        chk("cycle_after_clear", obs_rd, 32'd3);
        #2;
        force dut.cycle_r = 32'hFFFF_FFFF;
        #1;
        release dut.cycle_r;
        m_cyc = 32'hFFFF_FFFF;
        step(1'b0, 1'b0, MB + 32'd8, 32'h0, 1'b0);
        chk("cycle_max", obs_rd, 32'hFFFF_FFFF);
        step(1'b0, 1'b0, MB + 32'd8, 32'h0, 1'b0);
        chk("cycle_wrap", obs_rd, 32'h0);

        // Reset with bytes queued
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, MB, 32'h80 + i, 1'b0);
        step(1'b1, 1'b0, 32'h2000, 32'h0, 1'b0);
        step(1'b0, 1'b0, MB + 32'd8, 32'h0, 1'b0);
        chk("rst_cycle", obs_rd, 32'h0);
        chk("rst_txvalid", {31'b0, obs_v}, 32'h0);
        step(1'b0, 1'b0, MB + 32'd4, 32'h0, 1'b0);
        chk("rst_status", obs_rd, 32'h0000_0080);
        step(1'b0, 1'b0, 32'h10, 32'h0, 1'b0);
        chk("rst_ram_kept", obs_rd, 32'hDEAD_BEEF);
        step(1'b0, 1'b0, 32'h2000, 32'h0, 1'b0);
        chk("unmapped_read", obs_rd, 32'h0);

        // Random traffic against the model
        for (int k = 0; k < 800; k++) begin
            r = $urandom_range(0, 11);
            case (r)
                0, 1, 2, 3, 4: adr = ($urandom_range(0, 63) << 2) | $urandom_range(0, 3);
                5, 10, 11:     adr = MB | $urandom_range(0, 3);
                6:             adr = MB + 32'd4;
                7:             adr = (k % 5 == 0) ? MB + 32'd8 : MB + 32'd4;
                8:             adr = MB + 32'd12 + ($urandom_range(0, 20) << 2);
                default:       adr = $urandom;
            endcase
            step(($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0,
                 $urandom_range(0, 1) != 0, adr, $urandom,
                 (k % 200 < 100) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
